// File: rtl/serial_subtractor.sv
// Purpose: multi-cycle subtractor computing a - b - bin, CHUNK bits per clock.
// Latency: WIDTH/CHUNK cycles from the accepting edge to the done pulse.
// Backpressure: none; start is ignored while busy, and results hold until the next done.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, a, b, bin    request and operands, captured when start is seen in IDLE
//   busy, done          operation in progress, one-cycle result-update pulse
//   diff, bout, zero, ovf  result, final borrow, zero flag, two's-complement overflow
module serial_subtractor #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4     // WIDTH must be a multiple of CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] a_q;       // remaining minuend bits, current chunk at the bottom
    logic [WIDTH-1:0] b_q;       // remaining subtrahend bits, current chunk at the bottom
    logic [WIDTH-1:0] res_q;     // completed chunks, shifted in from the top
    logic             br_q;      // borrow into the current chunk (bin for chunk 0)
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             zero_q;
    logic             ovf_q;

    logic [CHUNK-1:0] x_c;
    logic [CHUNK-1:0] y_c;
    logic [CHUNK-1:0] d_c;
    logic             br_c;
    logic             br_out_c;
    logic             br_msb_in_c;
    logic [WIDTH-1:0] res_d;
    logic             last_c;

    // Ripple borrow chain across one chunk. The borrow entering the chunk's top
    // bit is kept because on the final chunk that is the borrow into the MSB.
    always_comb begin
        x_c         = a_q[CHUNK-1:0];
        y_c         = b_q[CHUNK-1:0];
        d_c         = '0;
        br_c        = br_q;
        br_msb_in_c = 1'b0;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) begin
                br_msb_in_c = br_c;
            end
            d_c[i] = x_c[i] ^ y_c[i] ^ br_c;
            br_c   = (~x_c[i] & y_c[i]) | (br_c & ~(x_c[i] ^ y_c[i]));
        end
        br_out_c = br_c;
        // After N shifts the first chunk has landed at bit 0, so res_d is the
        // fully aligned result on the last RUN cycle.
        res_d  = (res_q >> CHUNK) | (WIDTH'(d_c) << (WIDTH - CHUNK));
        last_c = (k_q == KW'(N - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        br_q    <= bin;
                        res_q   <= '0;
                        k_q     <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q   <= a_q >> CHUNK;
                    b_q   <= b_q >> CHUNK;
                    br_q  <= br_out_c;
                    res_q <= res_d;
                    k_q   <= k_q + KW'(1);
                    if (last_c) begin
                        state_q <= IDLE;
                        k_q     <= '0;
                        done_q  <= 1'b1;
                        diff_q  <= res_d;
                        bout_q  <= br_out_c;
                        zero_q  <= (res_d == '0);
                        ovf_q   <= br_msb_in_c ^ br_out_c;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign zero = zero_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Purpose: checks serial_subtractor (16/4 and 8/{1,2,4,8}) against an arithmetic model.
// Latency: done expected N cycles after the accepting edge.
// Backpressure: start pulses while busy must be ignored.
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst;
    int          tests = 0;
    int          fails = 0;

    // 16-bit, CHUNK=4 instance
    logic        start16;
    logic [15:0] a16, b16;
    logic        bin16;
    logic        busy16, done16, bout16, zero16, ovf16;
    logic [15:0] diff16;
    logic [15:0] exp16_prev = 16'h0;

    // 8-bit instances, CHUNK = 1, 2, 4, 8, driven in lockstep
    logic        start8;
    logic [7:0]  a8, b8;
    logic        bin8;
    logic [3:0]  busy8, done8, bout8, zero8, ovf8;
    logic [7:0]  diff8 [4];

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(16), .CHUNK(4)) u16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .bin(bin16),
        .busy(busy16), .done(done16), .diff(diff16), .bout(bout16),
        .zero(zero16), .ovf(ovf16)
    );

    for (genvar j = 0; j < 4; j++) begin : g8
        serial_subtractor #(.WIDTH(8), .CHUNK(1 << j)) u8 (
            .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
            .busy(busy8[j]), .done(done8[j]), .diff(diff8[j]), .bout(bout8[j]),
            .zero(zero8[j]), .ovf(ovf8[j])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Reference: plain integer arithmetic on w-bit operands.
    task automatic model(input int w, input logic [15:0] x, input logic [15:0] y, input logic bi,
                         output logic [15:0] d, output logic bo, output logic z, output logic o);
        longint full, sx, sy, s, half;
        half = longint'(1) << (w - 1);
        full = longint'(x) - longint'(y) - longint'(bi);
        d    = 16'(full & ((longint'(1) << w) - 1));
        bo   = (full < 0);
        z    = (d == 16'h0);
        sx   = (longint'(x) >= half) ? longint'(x) - 2 * half : longint'(x);
        sy   = (longint'(y) >= half) ? longint'(y) - 2 * half : longint'(y);
        s    = sx - sy - longint'(bi);
        o    = (s > half - 1) || (s < -half);
    endtask

    // One operation on the 16-bit instance; operands scrambled after acceptance.
    task automatic run16(input logic [15:0] ta, input logic [15:0] tbv, input logic tbi, input string tag);
        logic [15:0] ed;
        logic        eb, ez, eo;
        int          first, cnt;
        model(16, ta, tbv, tbi, ed, eb, ez, eo);
        @(negedge clk);
        a16 = ta; b16 = tbv; bin16 = tbi; start16 = 1'b1;
        first = 0; cnt = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start16 = 1'b0;
                a16 = 16'($urandom); b16 = 16'($urandom); bin16 = 1'($urandom);
                check({tag, " busy"}, 32'(busy16), 32'd1);
            end
            if (n == 3) check({tag, " hold"}, 32'(diff16), 32'(exp16_prev));
            if (done16) begin
                cnt++;
                if (first == 0) first = n;
            end
        end
        check({tag, " latency"}, 32'(first), 32'd5);
        check({tag, " dones"}, 32'(cnt), 32'd1);
        check({tag, " diff"}, 32'(diff16), 32'(ed));
        check({tag, " bout"}, 32'(bout16), 32'(eb));
        check({tag, " zero"}, 32'(zero16), 32'(ez));
        check({tag, " ovf"}, 32'(ovf16), 32'(eo));
        exp16_prev = ed;
    endtask

    // One operation on all four 8-bit instances at once.
    task automatic run8(input logic [7:0] ta, input logic [7:0] tbv, input logic tbi);
        logic [15:0] ed;
        logic        eb, ez, eo;
        int          first [4];
        int          cnt [4];
        model(8, {8'h0, ta}, {8'h0, tbv}, tbi, ed, eb, ez, eo);
        @(negedge clk);
        a8 = ta; b8 = tbv; bin8 = tbi; start8 = 1'b1;
        for (int j = 0; j < 4; j++) begin
            first[j] = 0; cnt[j] = 0;
        end
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start8 = 1'b0;
                a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
            end
            for (int j = 0; j < 4; j++) begin
                if (done8[j]) begin
                    cnt[j]++;
                    if (first[j] == 0) first[j] = n;
                end
            end
        end
        for (int j = 0; j < 4; j++) begin
            check($sformatf("c%0d latency %h-%h-%b", 1 << j, ta, tbv, tbi), 32'(first[j]), 32'((8 >> j) + 1));
            check($sformatf("c%0d dones", 1 << j), 32'(cnt[j]), 32'd1);
            check($sformatf("c%0d diff %h-%h-%b", 1 << j, ta, tbv, tbi), 32'(diff8[j]), 32'(ed[7:0]));
            check($sformatf("c%0d bout", 1 << j), 32'(bout8[j]), 32'(eb));
            check($sformatf("c%0d zero", 1 << j), 32'(zero8[j]), 32'(ez));
            check($sformatf("c%0d ovf", 1 << j), 32'(ovf8[j]), 32'(eo));
        end
    endtask

    initial begin : stim
        logic [15:0] ex, ey, ez16;
        logic        b0, z0, o0;
        int          cnt, first;

        // Reset, with start held high to show reset wins.
        rst = 1'b1;
        start16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0001; bin16 = 1'b1;
        start8 = 1'b1;  a8 = 8'hFF;     b8 = 8'h01;     bin8 = 1'b1;
        repeat (3) @(negedge clk);
        check("rst busy", 32'(busy16), 32'd0);
        check("rst done", 32'(done16), 32'd0);
        check("rst diff", 32'(diff16), 32'd0);
        check("rst flags", 32'({bout16, zero16, ovf16}), 32'd0);
        check("rst busy8", 32'(busy8), 32'd0);
        rst = 1'b0; start16 = 1'b0; start8 = 1'b0;
        @(negedge clk);
        check("post-rst idle", 32'(busy16), 32'd0);

        // Directed 16-bit cases.
        run16(16'h1234, 16'h0234, 1'b0, "basic");
        run16(16'h0000, 16'h0001, 1'b0, "underflow");
        run16(16'h8000, 16'h0001, 1'b0, "ovf");
        run16(16'h0005, 16'h0004, 1'b1, "zero");
        run16(16'h0100, 16'h0001, 1'b0, "chunk-borrow");
        run16(16'h7FFF, 16'hFFFF, 1'b0, "ovf-pos");

        // Start while busy is ignored; start in the done cycle is accepted.
        model(16, 16'hABCD, 16'h1111, 1'b0, ex, b0, z0, o0);
        model(16, 16'h0F0F, 16'hF0F0, 1'b1, ez16, b0, z0, o0);
        @(negedge clk);
        a16 = 16'hABCD; b16 = 16'h1111; bin16 = 1'b0; start16 = 1'b1;
        cnt = 0;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            start16 = (n == 2);
            if (n == 2) begin a16 = 16'h4444; b16 = 16'h0001; bin16 = 1'b1; end
            if (n < 5 && done16) cnt++;
        end
        check("busy-start early dones", 32'(cnt), 32'd0);
        check("busy-start done", 32'(done16), 32'd1);
        check("busy-start diff", 32'(diff16), 32'(ex));
        a16 = 16'h0F0F; b16 = 16'hF0F0; bin16 = 1'b1; start16 = 1'b1;
        cnt = 0; first = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            start16 = 1'b0;
            if (done16) begin
                cnt++;
                if (first == 0) first = n;
            end
        end
        check("b2b latency", 32'(first), 32'd5);
        check("b2b dones", 32'(cnt), 32'd1);
        check("b2b diff", 32'(diff16), 32'(ez16));
        exp16_prev = ez16;

        // Reset mid-operation aborts without a done pulse.
        @(negedge clk);
        a16 = 16'h1111; b16 = 16'h0222; bin16 = 1'b0; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", 32'(busy16), 32'd0);
        check("abort done", 32'(done16), 32'd0);
        check("abort diff", 32'(diff16), 32'd0);
        check("abort flags", 32'({bout16, zero16, ovf16}), 32'd0);
        cnt = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (done16) cnt++;
        end
        check("abort no done", 32'(cnt), 32'd0);
        exp16_prev = 16'h0;
        run16(16'h0003, 16'h0001, 1'b0, "after-abort");

        // Random 16-bit operations.
        for (int i = 0; i < 20; i++) begin
            run16(16'($urandom), 16'($urandom), 1'($urandom), "rand16");
        end

        // 8-bit instances: corners then random.
        run8(8'h00, 8'hFF, 1'b1);
        run8(8'h80, 8'h00, 1'b1);
        run8(8'h7F, 8'h80, 1'b0);
        run8(8'hFF, 8'hFF, 1'b0);
        for (int i = 0; i < 300; i++) begin
            run8(8'($urandom), 8'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
